serial_addsub_ctrl: RTL
=======================

# serial_addsub_ctrl

Bit-serial add/subtract sequencer that time-multiplexes a single 1-bit full-adder slice over a W-bit operand pair. It accepts a command (operands and operation) through a start/done handshake, steps the slice LSB-first for W cycles with a registered carry, and presents the W-bit result with carry-out and, optionally, signed overflow. It sits between a command source and the one-bit adder datapath and lets one slice do the work of a W-bit ripple adder.

## Interface
- W, 8, operand/result width in bits; legal range 2..32
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command request; sampled only in IDLE
- op_sub  in  1  0 = add (A+B), 1 = subtract (A−B); sampled with start
- a_in  in  W  operand A; sampled with start
- b_in  in  W  operand B; sampled with start
- abort  in  1  synchronous cancel of an operation in progress
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse, result valid
- result  out  W  last completed result
- cout  out  1  final carry of the last completed operation
- ovf  out  1  signed overflow of the last completed operation

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → latch a_in, b_in, op_sub into shift registers; bit counter := 0; carry := op_sub; go to RUN. start=0 → stay.
- RUN: slice inputs x = A[0], y = B[0] XOR op_sub, c = carry. Each edge: carry := maj(x,y,c); shift registers right one bit; sum bit x^y^c enters the result shift register at MSB; counter += 1. On the edge processing bit W−1 → DONE; result, cout, ovf registers updated from shift register and final carry on that same edge.
- DONE: done=1 for one cycle; next edge → IDLE.
- Arithmetic: subtract is A + ~B + 1 (two's complement). cout=1 on subtract means no borrow (A ≥ B unsigned). result is modulo 2^W.
- start while busy (RUN or DONE): ignored, not queued.
- abort in RUN or DONE: next edge → IDLE; done not pulsed; result/cout/ovf keep previous values. abort in IDLE: no effect. abort and start together in IDLE: start wins.
- Reset (any time, including mid-RUN): state IDLE; busy=0, done=0, result=0, cout=0, ovf=0, counter and carry 0.

## Timing
- Start sampled at edge T0 → RUN from T0; bits 0..W−1 processed at edges T1..TW; done high in cycle after TW; IDLE after T(W+1).
- Start-to-done latency W+1 edges; throughput one operation per W+2 cycles (start may be re-asserted the cycle after done).
- busy high from after T0 until after T(W+1); result, cout, ovf change only at TW, stable otherwise.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined: ovf = carry-into-MSB XOR carry-out-of-MSB, captured at TW (extra 1-bit register holding carry before the last bit).
- Not defined: ovf tied to 0, extra register removed; all other behaviour identical.

## Structure
- Package serial_addsub_pkg: state enum (IDLE, RUN, DONE), op encoding constants (OP_ADD=0, OP_SUB=1), default width constant.
- One sub-module: serial_fa_slice — purely combinational 1-bit slice (x, y, c → s = x^y^c, co = maj). Controller owns all state, the carry flop, and the B-inversion.

## Test plan
- W=8, add 0x3C + 0x15 → done after 9 edges, result 0x51, cout 0, ovf 0.
- Add 0xFF + 0x01 → result 0x00, cout 1, ovf 0; add 0x7F + 0x01 → result 0x80, cout 0, ovf 1 (0 with macro off).
- Subtract 0x10 − 0x01 → result 0x0F, cout 1; subtract 0x00 − 0x01 → result 0xFF, cout 0; subtract 0x80 − 0x01 → 0x7F, ovf 1.
- Second start pulsed during RUN and during DONE → ignored, one done pulse, result from first command only.
- abort at 4th RUN cycle after prior result 0x51 → IDLE next edge, no done, result stays 0x51; new start completes normally.
- rst_n low mid-RUN → all outputs 0 immediately; after release, fresh add 0x01 + 0x02 → 0x03.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// rtl/serial_addsub_pkg.sv - shared types and constants for the bit-serial add/subtract sequencer
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEFAULT_W = 8;

endpackage

// File: rtl/serial_fa_slice.sv
// rtl/serial_fa_slice.sv - combinational 1-bit full-adder slice
module serial_fa_slice (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ c;
  assign co = (x & y) | (x & c) | (y & c);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - bit-serial add/subtract sequencer driving one full-adder slice
// Optional: SERIAL_ADDSUB_OVF_EN enables the signed overflow output.
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t state, state_next;
  logic load, step, finish;

  logic [W-1:0]  a_sr, b_sr, r_sr, r_next;
  logic [CW-1:0] cnt;
  logic          carry, sub_q;
  logic          slice_y, slice_s, slice_co;
  logic          last_bit;

  assign last_bit = (cnt == CW'(W - 1));
  // The subtrahend is inverted bit by bit; the +1 comes from the carry seed.
  assign slice_y  = b_sr[0] ^ sub_q;
  assign r_next   = {slice_s, r_sr[W-1:1]};

  serial_fa_slice u_slice (
    .x  (a_sr[0]),
    .y  (slice_y),
    .c  (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (last_bit) begin
            finish     = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (load) begin
      a_sr  <= a_in;
      b_sr  <= b_in;
      r_sr  <= '0;
      cnt   <= '0;
      carry <= (op_sub == OP_SUB);
      sub_q <= (op_sub != OP_ADD);
    end else if (step) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      r_sr  <= r_next;
      cnt   <= cnt + CW'(1);
      carry <= slice_co;
      if (finish) begin
        result <= r_next;
        cout   <= slice_co;
`ifdef SERIAL_ADDSUB_OVF_EN
        // carry still holds the carry into the MSB on this edge
        ovf_q  <= carry ^ slice_co;
`endif
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
